// File: rtl/sd_init_seq.sv
// sd_init_seq: SPI-mode SD card power-up / initialisation sequencer.
// Sends the dummy clocks, then CMD0, CMD8, CMD55/ACMD41 (repeated until the
// card is ready), CMD58 and, for byte-addressed (SDSC) cards, CMD16. It drives
// the byte-level SPI master through an en/val handshake and owns chip select
// for as long as busy_o is high.
// Optional build macro: SD_V1_FALLBACK_EN. When it is defined, a card that
// rejects CMD8 as illegal is initialised as a v1 card. When it is undefined,
// that card ends in ERR with code 2.
module sd_init_seq #(
   parameter int DUMMY_BYTES    = 10,
   parameter int RESP_POLL      = 8,
   parameter int ACMD41_RETRIES = 1000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic [7:0] spi_data_out_i,
   input  logic       spi_val_i,
   output logic [7:0] spi_data_in_o,
   output logic       spi_en_o,
   output logic       spi_we_o,
   output logic       sd_cs_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [2:0] err_code_o,
   output logic       sdhc_o
);

   localparam logic [7:0]  DUMMY_N = 8'(DUMMY_BYTES);
   localparam logic [7:0]  POLL_N  = 8'(RESP_POLL);
   localparam logic [15:0] RETRY_N = 16'(ACMD41_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE, S_DUMMY, S_FRAME, S_POLL, S_TRAIL, S_TAIL, S_DONE, S_ERR
   } state_t;

   // C_FIN marks "no further command": the sequence ends in DONE
   typedef enum logic [2:0] {
      C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58, C_CMD16, C_FIN
   } cmd_t;

   // Byte i (0..5) of the 6-byte command frame for command c
   function automatic logic [7:0] frame_byte(input cmd_t c, input logic [2:0] i, input logic v1);
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  crc;
      logic [7:0]  b;
      case (c)
         C_CMD0:   begin idx = 6'd0;  arg = 32'h0000_0000; crc = 8'h95; end
         C_CMD8:   begin idx = 6'd8;  arg = 32'h0000_01AA; crc = 8'h87; end
         C_CMD55:  begin idx = 6'd55; arg = 32'h0000_0000; crc = 8'h65; end
         C_ACMD41: begin
            idx = 6'd41;
            arg = v1 ? 32'h0000_0000 : 32'h4000_0000;
            crc = v1 ? 8'hE5 : 8'h77;
         end
         C_CMD58:  begin idx = 6'd58; arg = 32'h0000_0000; crc = 8'hFD; end
         C_CMD16:  begin idx = 6'd16; arg = 32'h0000_0200; crc = 8'h15; end
         default:  begin idx = 6'd0;  arg = 32'h0000_0000; crc = 8'hFF; end
      endcase
      case (i)
         3'd0:    b = {2'b01, idx};
         3'd1:    b = arg[31:24];
         3'd2:    b = arg[23:16];
         3'd3:    b = arg[15:8];
         3'd4:    b = arg[7:0];
         3'd5:    b = crc;
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

   state_t      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   cmd_t        nxt_q, nxt_d;
   logic [2:0]  pend_q, pend_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] retry_q, retry_d;
   logic [7:0]  r1_q, r1_d;
   logic [7:0]  echo_q, echo_d;
   logic        ccs_q, ccs_d;
   logic        v1_q, v1_d;
   logic [7:0]  data_q, data_d;
   logic        en_q, en_d;
   logic        cs_q, cs_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [2:0]  code_q, code_d;
   logic        sdhc_q, sdhc_d;

   logic        eval_s;
   logic [7:0]  r1_s;
   logic [7:0]  rx_s;

   // Next-state logic: byte handshake, command sequencing and response checks
   always_comb begin
      state_d = state_q;  cmd_d   = cmd_q;    nxt_d  = nxt_q;   pend_d = pend_q;
      cnt_d   = cnt_q;    idx_d   = idx_q;    retry_d = retry_q; r1_d  = r1_q;
      echo_d  = echo_q;   ccs_d   = ccs_q;    v1_d   = v1_q;    data_d = data_q;
      en_d    = en_q;     cs_d    = cs_q;     busy_d = busy_q;  done_d = done_q;
      err_d   = err_q;    code_d  = code_q;   sdhc_d = sdhc_q;
      eval_s  = 1'b0;
      r1_s    = 8'hFF;
      rx_s    = spi_data_out_i;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            en_d = 1'b0;
            cs_d = 1'b1;
            if (start_i) begin
               busy_d  = 1'b1;   done_d = 1'b0;   err_d  = 1'b0;
               code_d  = 3'd0;   sdhc_d = 1'b0;   v1_d   = 1'b0;
               retry_d = 16'd0;  cnt_d  = 8'd0;   idx_d  = 3'd0;
               data_d  = 8'hFF;  state_d = S_DUMMY;
            end else begin
               busy_d = 1'b0;
            end
         end
         S_DUMMY, S_FRAME, S_POLL, S_TRAIL, S_TAIL: begin
            if (!en_q) begin
               // GAP cycle is over: start the next byte; CS is only high for dummy clocks
               en_d = 1'b1;
               cs_d = (state_q == S_DUMMY);
            end else if (spi_val_i) begin
               en_d = 1'b0;
               case (state_q)
                  S_DUMMY: begin
                     if (cnt_q + 8'd1 == DUMMY_N) begin
                        state_d = S_FRAME;
                        cmd_d   = C_CMD0;
                        idx_d   = 3'd0;
                        cnt_d   = 8'd0;
                        data_d  = frame_byte(C_CMD0, 3'd0, v1_q);
                     end else begin
                        cnt_d = cnt_q + 8'd1;
                     end
                  end
                  S_FRAME: begin
                     if (idx_q == 3'd5) begin
                        state_d = S_POLL;
                        cnt_d   = 8'd0;
                        data_d  = 8'hFF;
                     end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = frame_byte(cmd_q, idx_q + 3'd1, v1_q);
                     end
                  end
                  S_POLL: begin
                     data_d = 8'hFF;
                     if (!rx_s[7]) begin
                        r1_d = rx_s;
                        // an illegal-command CMD8 reply is R1 only, without the R7 body
                        if ((cmd_q == C_CMD58) || ((cmd_q == C_CMD8) && !rx_s[2])) begin
                           state_d = S_TRAIL;
                           idx_d   = 3'd0;
                        end else begin
                           eval_s  = 1'b1;
                           r1_s    = rx_s;
                           state_d = S_TAIL;
                        end
                     end else if (cnt_q + 8'd1 == POLL_N) begin
                        state_d = S_ERR;  err_d  = 1'b1;  code_d = 3'd3;
                        busy_d  = 1'b0;   cs_d   = 1'b1;
                     end else begin
                        cnt_d = cnt_q + 8'd1;
                     end
                  end
                  S_TRAIL: begin
                     data_d = 8'hFF;
                     echo_d = rx_s;
                     if (idx_q == 3'd0) begin
                        ccs_d = rx_s[6];
                     end else begin
                        ccs_d = ccs_q;
                     end
                     if (idx_q == 3'd3) begin
                        eval_s  = 1'b1;
                        r1_s    = r1_q;
                        state_d = S_TAIL;
                     end else begin
                        idx_d = idx_q + 3'd1;
                     end
                  end
                  S_TAIL: begin
                     // CS goes high for the GAP cycle that follows every command
                     cs_d   = 1'b1;
                     data_d = 8'hFF;
                     if (pend_q != 3'd0) begin
                        state_d = S_ERR;  err_d = 1'b1;  code_d = pend_q;  busy_d = 1'b0;
                     end else if (nxt_q == C_FIN) begin
                        state_d = S_DONE; done_d = 1'b1; busy_d = 1'b0;
                     end else begin
                        state_d = S_FRAME;
                        cmd_d   = nxt_q;
                        idx_d   = 3'd0;
                        data_d  = frame_byte(nxt_q, 3'd0, v1_q);
                     end
                  end
                  default: state_d = S_IDLE;
               endcase
            end else begin
               en_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Response evaluation: decides the follow-up command or a pending error code
      if (eval_s) begin
         pend_d = 3'd0;
         nxt_d  = C_FIN;
         case (cmd_q)
            C_CMD0: begin
               if (r1_s == 8'h01) nxt_d = C_CMD8; else pend_d = 3'd1;
            end
            C_CMD8: begin
               if (r1_s[2]) begin
`ifdef SD_V1_FALLBACK_EN
                  v1_d  = 1'b1;
                  nxt_d = C_CMD55;
`else
                  pend_d = 3'd2;
`endif
               end else if ((r1_s == 8'h01) && ({echo_q, rx_s} == 16'h01AA)) begin
                  nxt_d = C_CMD55;
               end else begin
                  pend_d = 3'd2;
               end
            end
            C_CMD55: begin
               if ((r1_s == 8'h00) || (r1_s == 8'h01)) nxt_d = C_ACMD41; else pend_d = 3'd4;
            end
            C_ACMD41: begin
               if (r1_s == 8'h00) begin
                  nxt_d = v1_q ? C_CMD16 : C_CMD58;
               end else if (r1_s == 8'h01) begin
                  retry_d = retry_q + 16'd1;
                  if (retry_q + 16'd1 == RETRY_N) pend_d = 3'd4; else nxt_d = C_CMD55;
               end else begin
                  pend_d = 3'd4;
               end
            end
            C_CMD58: begin
               if (r1_s == 8'h00) begin
                  sdhc_d = ccs_q;
                  nxt_d  = ccs_q ? C_FIN : C_CMD16;
               end else begin
                  pend_d = 3'd5;
               end
            end
            C_CMD16: begin
               if (r1_s == 8'h00) nxt_d = C_FIN; else pend_d = 3'd5;
            end
            default: pend_d = 3'd5;
         endcase
      end else begin
         pend_d = pend_q;
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;  cmd_q   <= C_CMD0;  nxt_q  <= C_CMD0;  pend_q <= 3'd0;
         cnt_q   <= 8'd0;    idx_q   <= 3'd0;    retry_q <= 16'd0;  r1_q   <= 8'hFF;
         echo_q  <= 8'd0;    ccs_q   <= 1'b0;    v1_q   <= 1'b0;    data_q <= 8'hFF;
         en_q    <= 1'b0;    cs_q    <= 1'b1;    busy_q <= 1'b0;    done_q <= 1'b0;
         err_q   <= 1'b0;    code_q  <= 3'd0;    sdhc_q <= 1'b0;
      end else begin
         state_q <= state_d; cmd_q   <= cmd_d;   nxt_q  <= nxt_d;   pend_q <= pend_d;
         cnt_q   <= cnt_d;   idx_q   <= idx_d;   retry_q <= retry_d; r1_q  <= r1_d;
         echo_q  <= echo_d;  ccs_q   <= ccs_d;   v1_q   <= v1_d;    data_q <= data_d;
         en_q    <= en_d;    cs_q    <= cs_d;    busy_q <= busy_d;  done_q <= done_d;
         err_q   <= err_d;   code_q  <= code_d;  sdhc_q <= sdhc_d;
      end
   end

   assign spi_data_in_o = data_q;
   assign spi_en_o      = en_q;
   assign spi_we_o      = en_q;
   assign sd_cs_o       = cs_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign err_code_o    = code_q;
   assign sdhc_o        = sdhc_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// Directed bench for sd_init_seq: an SPI slave plus a small SD card model
// answers the sequencer; the initial block runs one scenario after another.
module tb_sd_init_seq;

   logic       clk_i;
   logic       rst_i;
   logic       start_i;
   logic [7:0] spi_data_out_i;
   logic       spi_val_i;
   logic [7:0] spi_data_in_o;
   logic       spi_en_o;
   logic       spi_we_o;
   logic       sd_cs_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic [2:0] err_code_o;
   logic       sdhc_o;

   int checks = 0;
   int errors = 0;

   // card model state and configuration
   logic [7:0]  fb [6];
   int          fcnt;
   logic [7:0]  resp [$];
   int          dummy_lead;
   logic        framed_any;
   int          n41;
   int          n55;
   int          post_bytes;
   logic        cmd16_seen;
   logic [31:0] acmd41_arg;
   logic [7:0]  cfg_cmd8_r1;
   int          cfg_ones;
   logic [7:0]  cfg_ocr0;
   logic        cfg_mute;
   logic [7:0]  cfg_cmd16_r1;
   logic [7:0]  rxb;

   sd_init_seq #(.DUMMY_BYTES(10), .RESP_POLL(8), .ACMD41_RETRIES(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .spi_data_out_i(spi_data_out_i), .spi_val_i(spi_val_i),
      .spi_data_in_o(spi_data_in_o), .spi_en_o(spi_en_o), .spi_we_o(spi_we_o),
      .sd_cs_o(sd_cs_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .err_code_o(err_code_o), .sdhc_o(sdhc_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input logic [7:0] c8, input int ones, input logic [7:0] ocr0,
                              input logic mute, input logic [7:0] c16);
      fcnt = 0; resp.delete(); dummy_lead = 0; framed_any = 1'b0;
      n41 = 0; n55 = 0; post_bytes = 0; cmd16_seen = 1'b0; acmd41_arg = 32'hFFFF_FFFF;
      cfg_cmd8_r1 = c8; cfg_ones = ones; cfg_ocr0 = ocr0; cfg_mute = mute; cfg_cmd16_r1 = c16;
   endtask

   task automatic decode();
      if (!cfg_mute) begin
         case (fb[0][5:0])
            6'd0:  begin resp.push_back(8'hFF); resp.push_back(8'h01); end
            6'd8:  begin
               resp.push_back(8'hFF);
               if (cfg_cmd8_r1[2]) resp.push_back(cfg_cmd8_r1);
               else begin
                  resp.push_back(8'h01); resp.push_back(8'h00); resp.push_back(8'h00);
                  resp.push_back(8'h01); resp.push_back(8'hAA);
               end
            end
            6'd55: begin n55++; resp.push_back(8'hFF); resp.push_back(8'h01); end
            6'd41: begin
               n41++;
               acmd41_arg = {fb[1], fb[2], fb[3], fb[4]};
               resp.push_back(8'hFF);
               resp.push_back((n41 <= cfg_ones) ? 8'h01 : 8'h00);
            end
            6'd58: begin
               resp.push_back(8'hFF); resp.push_back(8'h00); resp.push_back(cfg_ocr0);
               resp.push_back(8'hFF); resp.push_back(8'h80); resp.push_back(8'h00);
            end
            6'd16: begin
               cmd16_seen = (fb[0] == 8'h50) && (fb[1] == 8'h00) && (fb[2] == 8'h00) &&
                            (fb[3] == 8'h02) && (fb[4] == 8'h00) && (fb[5] == 8'h15);
               resp.push_back(8'hFF); resp.push_back(cfg_cmd16_r1);
            end
            default: ;
         endcase
      end
   endtask

   task automatic card_byte(input logic [7:0] tx, input logic cs, output logic [7:0] rx);
      if (resp.size() > 0) rx = resp.pop_front(); else rx = 8'hFF;
      if (cs) begin
         if (!framed_any) dummy_lead++;
      end else if (fcnt == 0 && tx[7:6] == 2'b01) begin
         fb[0] = tx; fcnt = 1;
      end else if (fcnt > 0) begin
         fb[fcnt] = tx; fcnt++;
         if (fcnt == 6) begin
            fcnt = 0; framed_any = 1'b1; post_bytes = 0;
            decode();
         end
      end else begin
         post_bytes++;
      end
   endtask

   // SPI slave: answers each request one cycle later with a single-cycle val pulse
   initial begin
      spi_val_i = 1'b0;
      spi_data_out_i = 8'hFF;
      forever begin
         @(negedge clk_i);
         if (spi_en_o === 1'b1) begin
            @(negedge clk_i);
            card_byte(spi_data_in_o, sd_cs_o, rxb);
            spi_data_out_i = rxb;
            spi_val_i = 1'b1;
            @(negedge clk_i);
            spi_val_i = 1'b0;
         end
      end
   end

   task automatic do_start();
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n;
      n = 0;
      while (done_o !== 1'b1 && err_o !== 1'b1 && n < budget) begin
         @(negedge clk_i); n++;
      end
      checks++;
      assert (n < budget) else begin
         errors++;
         $error("FAIL %s_timeout observed=%0d expected_below=%0d", tag, n, budget);
      end
   endtask

   initial begin
      int n;
      rst_i = 1'b1; start_i = 1'b0;
      model_reset(8'h01, 2, 8'hC0, 1'b0, 8'h00);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_cs", sd_cs_o, 1'b1);
      chk("rst_en", spi_en_o, 1'b0);
      chk("rst_we", spi_we_o, 1'b0);
      chk("rst_data", spi_data_in_o, 8'hFF);
      chk("rst_flags", {busy_o, done_o, err_o, err_code_o, sdhc_o}, 7'd0);

      // SDHC card
      model_reset(8'h01, 2, 8'hC0, 1'b0, 8'h00);
      do_start();
      chk("hc_busy", busy_o, 1'b1);
      wait_end("hc", 5000);
      chk("hc_done", done_o, 1'b1);
      chk("hc_err", err_o, 1'b0);
      chk("hc_sdhc", sdhc_o, 1'b1);
      chk("hc_idle", {busy_o, sd_cs_o, spi_en_o}, 3'b010);
      chk("hc_dummy", dummy_lead, 10);
      chk("hc_no16", cmd16_seen, 1'b0);
      chk("hc_n41", n41, 3);
      chk("hc_n55", n55, 3);
      chk("hc_arg41", acmd41_arg, 32'h4000_0000);

      // SDSC card
      model_reset(8'h01, 0, 8'h80, 1'b0, 8'h00);
      do_start();
      wait_end("sc", 5000);
      chk("sc_done", done_o, 1'b1);
      chk("sc_sdhc", sdhc_o, 1'b0);
      chk("sc_cmd16", cmd16_seen, 1'b1);

      // card never answers
      model_reset(8'h01, 0, 8'hC0, 1'b1, 8'h00);
      do_start();
      wait_end("mute", 5000);
      chk("mute_err", {done_o, err_o}, 2'b01);
      chk("mute_code", err_code_o, 3'd3);
      chk("mute_polls", post_bytes, 8);

      // ACMD41 never ready
      model_reset(8'h01, 1000, 8'hC0, 1'b0, 8'h00);
      do_start();
      wait_end("rty", 5000);
      chk("rty_err", err_o, 1'b1);
      chk("rty_code", err_code_o, 3'd4);
      chk("rty_n41", n41, 4);

      // CMD8 rejected as illegal command
      model_reset(8'h05, 0, 8'hC0, 1'b0, 8'h00);
      do_start();
      wait_end("v1", 5000);
`ifdef SD_V1_FALLBACK_EN
      chk("v1_done", {done_o, err_o}, 2'b10);
      chk("v1_sdhc", sdhc_o, 1'b0);
      chk("v1_arg41", acmd41_arg, 32'h0000_0000);
      chk("v1_cmd16", cmd16_seen, 1'b1);
`else
      chk("v1_err", {done_o, err_o}, 2'b01);
      chk("v1_code", err_code_o, 3'd2);
      chk("v1_n55", n55, 0);
`endif

      // reset in the middle of an ACMD41 frame, then rerun
      model_reset(8'h01, 1000, 8'hC0, 1'b0, 8'h00);
      do_start();
      n = 0;
      while (!(fcnt == 2 && fb[0] == 8'h69 && spi_en_o === 1'b1) && n < 5000) begin
         @(negedge clk_i); n++;
      end
      chk("mid_reached", (n < 5000), 1'b1);
      rst_i = 1'b1;
      #1;
      chk("mid_cs", sd_cs_o, 1'b1);
      chk("mid_en", spi_en_o, 1'b0);
      chk("mid_busy", busy_o, 1'b0);
      repeat (4) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (8) @(negedge clk_i);
      model_reset(8'h01, 2, 8'hC0, 1'b0, 8'h00);
      do_start();
      wait_end("rerun", 5000);
      chk("rerun_dummy", dummy_lead, 10);
      chk("rerun_done", done_o, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_init_seq.md
Name: sd_init_seq

Overview:
SD card power-up/initialisation sequencer in SPI mode. It drives the byte-level SPI master through a request/valid handshake and owns chip select during init. It issues dummy clocks, CMD0, CMD8, a CMD55/ACMD41 loop, CMD58 and, for SDSC cards, CMD16. It sits beside the SD command controller; the card wrapper muxes SPI master control to this block while busy_o=1.

Parameters:
DUMMY_BYTES, 10, number of 0xFF bytes sent with CS high (80 clocks).
RESP_POLL, 8, maximum 0xFF poll bytes while waiting for an R1 start (bit7=0).
ACMD41_RETRIES, 1000, maximum CMD55/ACMD41 iterations before error; retry counter is 16 bits.

Ports:
clk_i  in  1  system clock (APB pclk)
rst_i  in  1  asynchronous active-high reset
start_i  in  1  single-cycle start pulse; ignored while busy_o=1
spi_data_out_i  in  8  byte received by SPI master
spi_val_i  in  1  SPI master transfer-complete pulse
spi_data_in_o  out  8  byte to transmit
spi_en_o  out  1  transfer request (level)
spi_we_o  out  1  write enable to SPI master
sd_cs_o  out  1  card chip select, active low
busy_o  out  1  sequence in progress
done_o  out  1  init succeeded (level)
err_o  out  1  init failed (level)
err_code_o  out  3  failure cause
sdhc_o  out  1  card reports CCS=1 (block addressing)

Behaviour:
- Reset, async on rst_i high, also mid-sequence: spi_en_o=0, spi_we_o=0, spi_data_in_o=0xFF, sd_cs_o=1, busy_o=0, done_o=0, err_o=0, err_code_o=0, sdhc_o=0, FSM=IDLE, all counters 0.
- Byte transfer: XFER raises spi_en_o=1 and spi_we_o=1 with spi_data_in_o stable, and holds them until spi_val_i=1. spi_data_out_i is captured on that same edge. The next cycle is GAP with spi_en_o=0 for exactly 1 cycle, then the next byte. spi_val_i while spi_en_o=0 is ignored.
- start_i in IDLE/DONE/ERR: clear done_o, err_o, err_code_o and sdhc_o; set busy_o=1 on the next cycle.
- States: IDLE -> DUMMY -> CMD0 -> CMD8 -> CMD55 -> ACMD41 -> CMD58 -> [CMD16] -> DONE. Any failure goes to ERR.
- DUMMY: sd_cs_o=1; send DUMMY_BYTES x 0xFF.
- Command frame: sd_cs_o=0; send 6 bytes {0x40|idx, arg[31:24..7:0], crc}.
  - CMD0: arg 0, crc 0x95.
  - CMD8: arg 0x000001AA, crc 0x87.
  - CMD55: arg 0, crc 0x65.
  - ACMD41: arg 0x40000000, crc 0x77.
  - CMD58: arg 0, crc 0xFD.
  - CMD16: arg 0x00000200, crc 0x15.
- Response poll: send 0xFF until the received byte has bit7=0 (R1). If RESP_POLL bytes pass without R1, go to ERR with code 3.
- Trailer: CMD8 and CMD58 read 4 more bytes after R1 (R7/R3). Every command then sends one 0xFF with CS low and raises sd_cs_o=1 for one GAP cycle.
- CMD0: R1 must equal 0x01, else code 1.
- CMD8:
  - R1=0x01 and trailer bytes 3..4 = 0x01,0xAA: continue.
  - Echo mismatch: code 2.
  - R1 bit2 set (illegal command): handled by the optional feature.
- CMD55: R1 must be 0x00 or 0x01, else code 4.
- ACMD41:
  - R1=0x00: go to CMD58.
  - R1=0x01: retry counter +1. If counter == ACMD41_RETRIES, code 4; else back to CMD55.
  - Other R1 values: code 4.
- CMD58: R1 must be 0x00, else code 5. sdhc_o takes OCR byte0 bit6.
  - CCS=1: go to DONE.
  - CCS=0: send CMD16.
- CMD16: R1 must be 0x00 -> DONE, else code 5.
- DONE: busy_o=0, done_o=1. ERR: busy_o=0, err_o=1, err_code_o latched. In both, sd_cs_o=1 and spi_en_o=0. Flags hold until the next start_i.

Optional Feature:
SD_V1_FALLBACK_EN.
- Defined: CMD8 R1 with bit2 set selects v1 mode. ACMD41 uses arg 0x00000000 (crc 0xE5), CMD58 is skipped, sdhc_o=0, and CMD16 is always issued.
- Undefined: that response gives ERR with code 2.

Test Plan:
- SDHC card model (CMD0->0x01, CMD8 echo 01AA, ACMD41 0x01 twice then 0x00, OCR byte0 0xC0) -> exactly 10 leading 0xFF bytes with CS high; done_o=1, sdhc_o=1, no CMD16 frame, three CMD55/ACMD41 pairs.
- SDSC card (OCR byte0 0x80, CMD16 R1 0x00) -> frame 0x50 00 00 02 00 15 seen; done_o=1, sdhc_o=0.
- Card never answers (MISO 0xFF) -> after CMD0 plus 8 poll bytes: err_o=1, err_code_o=3.
- ACMD41 always 0x01, ACMD41_RETRIES=4 -> exactly 4 ACMD41 frames, then err_code_o=4.
- CMD8 R1=0x05 -> with macro: ACMD41 arg 0, done_o=1, sdhc_o=0; without: err_code_o=2.
- rst_i asserted mid-ACMD41 byte -> same cycle sd_cs_o=1, spi_en_o=0, busy_o=0; new start_i reruns DUMMY.
